tile_result_drain: RTL
======================

TILE_RESULT_DRAIN -- requirements
Module: tile_result_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the output element width.
REQ-002 SHALL have parameter ACC_WIDTH, default 16, the PE accumulator width.
REQ-003 SHALL have parameter TILE, default 4, the systolic array edge.
REQ-004 SHALL have parameters M_SIZE, default 12, and N_SIZE, default 12, giving the C matrix rows and columns.
REQ-005 SHALL have parameter ADDR_W, default 10, the write address width.
REQ-006 SHALL have port clk, input, 1 bit, the clock.
REQ-007 SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-008 SHALL have port start, input, 1 bit, which begins a new matrix.
REQ-009 SHALL have port tile_valid, input, 1 bit, meaning the array holds a finished tile.
REQ-010 SHALL have port tile_ready, output, 1 bit, meaning the drain can accept a tile.
REQ-011 SHALL have port tile_data, input, TILE*TILE*ACC_WIDTH bits; element e=r*TILE+c is slice [e*ACC_WIDTH +: ACC_WIDTH] and holds PE(r,c).
REQ-012 SHALL have port wr_valid, input... correction: wr_valid is an output, 1 bit, meaning a write request.
REQ-013 SHALL have port wr_ready, input, 1 bit, meaning the memory accepts the write.
REQ-014 SHALL have port wr_addr, output, ADDR_W bits, the row-major C address.
REQ-015 SHALL have port wr_data, output, DATA_WIDTH bits, the converted element.
REQ-016 SHALL have port busy, output, 1 bit, high while in DRAIN.
REQ-017 SHALL have port done, output, 1 bit, a one-cycle pulse when the matrix is complete.

Function
REQ-018 SHALL use an FSM with states IDLE, DRAIN and DONE.
REQ-019 SHALL drive tile_ready=1 only in IDLE.
REQ-020 SHALL, on tile_valid&tile_ready, register all of tile_data, set elem=0, and enter DRAIN.
REQ-021 SHALL assert wr_valid the cycle after acceptance and hold wr_valid/addr/data stable until wr_ready.
REQ-022 SHALL advance elem on each wr_valid&wr_ready; wr_valid stays high with no bubbles while wr_ready stays high.
REQ-023 SHALL compute wr_addr = (tr*TILE + r)*N_SIZE + tc*TILE + c, where tr = tile_idx / (N_SIZE/TILE) and tc = tile_idx % (N_SIZE/TILE).
REQ-024 SHALL leave DRAIN after element TILE*TILE-1 is accepted: to DONE if tile_idx is the last tile ((M_SIZE/TILE)*(N_SIZE/TILE)-1), otherwise to IDLE with tile_idx+1.
REQ-025 SHALL pulse done for exactly one cycle in DONE, then return to IDLE with tile_idx=0 (wrap-around).
REQ-026 SHALL clear tile_idx to 0 when start is high in IDLE; start SHALL be ignored in DRAIN and DONE.
REQ-027 SHALL give start priority over tile_valid when both are high in IDLE: tile_idx is cleared and that tile is not accepted.
REQ-028 SHALL, without SATURATE_EN, produce wr_data from the low DATA_WIDTH bits of the element (truncation).
REQ-029 SHALL hold tile_data sampling closed (tile_ready=0) during DRAIN, so the captured tile is unaffected by input changes.

Reset
REQ-030 SHALL, on rst_n low at any time, including mid-drain, force IDLE and set tile_idx=0, elem=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0; tile_ready is 1 after reset.
REQ-031 SHALL discard any partially drained tile on reset, with no further writes.

Configuration
REQ-032 SHALL, with macro TILE_RESULT_SATURATE_EN defined, clamp each element to 2^DATA_WIDTH-1 when its value exceeds it (unsigned).
REQ-033 SHALL, without TILE_RESULT_SATURATE_EN, truncate per REQ-028; address generation and timing SHALL be identical in both builds.

Structure
REQ-034 SHALL take DATA_WIDTH/ACC_WIDTH/TILE defaults, the FSM state enum and a tiles-per-row constant function from the shared systolic package.
REQ-035 SHALL contain one sub-module, tile_addr_gen (tile_idx, elem -> wr_addr); the rest SHALL be flat.
REQ-036 SHALL elaborate-time check that M_SIZE and N_SIZE are multiples of TILE, and that ADDR_W covers M_SIZE*N_SIZE.

Verification
REQ-037 SHALL test a single tile with elements 0..15 and wr_ready tied high: 16 writes on consecutive cycles, addr 0,1,2,3,12,13,14,15,24,...,39; data 0..15.
REQ-038 SHALL test a full 12x12 matrix of 9 tiles with elem value = global address: every address 0..143 written once, and done pulses once after address 143.
REQ-039 SHALL test random wr_ready stalls: wr_addr/wr_data are held while stalled, and the write sequence is unchanged.
REQ-040 SHALL test element value 300: wr_data=44 without the macro and 255 with TILE_RESULT_SATURATE_EN.
REQ-041 SHALL test rst_n low after the 5th write of tile 4: no further writes, tile_ready=1, and the next tile writes at addresses 0..39.
REQ-042 SHALL test start and tile_valid high together in IDLE after 3 tiles: the tile is not accepted, and the next accepted tile writes to address 0.

Source files
------------

// File: rtl/tile_result_drain_pkg.sv
// Shared systolic-array definitions for the result drain path:
// default widths, drain FSM states and tile geometry helpers.
package tile_result_drain_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF  = 16;
    localparam int TILE_DEF       = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_DONE
    } drain_state_e;

    function automatic int tiles_per_row(input int n_size, input int tile);
        return n_size / tile;
    endfunction

endpackage

// File: rtl/tile_result_drain_addr_gen.sv
// tile_addr_gen: maps (tile index, element index) to the row-major
// address of that element in the C matrix.
module tile_addr_gen
    import tile_result_drain_pkg::*;
#(
    parameter int TILE   = TILE_DEF,
    parameter int N_SIZE = 12,
    parameter int ADDR_W = 10,
    parameter int TIDX_W = 4,
    parameter int ELEM_W = 4
) (
    input  logic [TIDX_W-1:0] tile_idx,
    input  logic [ELEM_W-1:0] elem,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam int TPR = tiles_per_row(N_SIZE, TILE);

    int unsigned ti;
    int unsigned el;
    int unsigned row;
    int unsigned col;

    always_comb begin
        ti      = 32'(tile_idx);
        el      = 32'(elem);
        row     = (ti / TPR) * TILE + el / TILE;
        col     = (ti % TPR) * TILE + el % TILE;
        wr_addr = ADDR_W'(row * N_SIZE + col);
    end

endmodule

// File: rtl/tile_result_drain.sv
// Drains finished systolic tiles into C memory, one element per write.
// Build option: TILE_RESULT_SATURATE_EN clamps elements instead of truncating.
module tile_result_drain
    import tile_result_drain_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
    parameter int TILE       = TILE_DEF,
    parameter int M_SIZE     = 12,
    parameter int N_SIZE     = 12,
    parameter int ADDR_W     = 10
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           tile_valid,
    output logic                           tile_ready,
    input  logic [TILE*TILE*ACC_WIDTH-1:0] tile_data,
    output logic                           wr_valid,
    input  logic                           wr_ready,
    output logic [ADDR_W-1:0]              wr_addr,
    output logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           busy,
    output logic                           done
);

    localparam int NUM_TILES = (M_SIZE / TILE) * tiles_per_row(N_SIZE, TILE);
    localparam int NELEM     = TILE * TILE;
    localparam int TIDX_W    = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int ELEM_W    = $clog2(NELEM);

    if ((M_SIZE % TILE) != 0 || (N_SIZE % TILE) != 0) begin : g_bad_tiling
        $error("M_SIZE and N_SIZE must be multiples of TILE");
    end
    if (longint'(M_SIZE) * longint'(N_SIZE) > (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("ADDR_W too narrow for M_SIZE*N_SIZE");
    end
    if (ACC_WIDTH <= DATA_WIDTH) begin : g_bad_width
        $error("ACC_WIDTH must exceed DATA_WIDTH");
    end

    drain_state_e state_q;
    drain_state_e state_d;

    logic [TIDX_W-1:0]    tile_idx;
    logic [ELEM_W-1:0]    elem;
    logic [ACC_WIDTH-1:0] tile_q [NELEM];
    logic [ACC_WIDTH-1:0] elem_val;
    logic                 elem_last;
    logic                 tile_last;

    assign elem_last = (elem == ELEM_W'(NELEM - 1));
    assign tile_last = (tile_idx == TIDX_W'(NUM_TILES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        tile_ready = 1'b0;
        wr_valid   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tile_ready = 1'b1;
                if (!start && tile_valid) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                wr_valid = 1'b1;
                busy     = 1'b1;
                if (wr_ready && elem_last)
                    state_d = tile_last ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // start wins over tile_valid: the tile offered alongside it is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_idx <= '0;
            elem     <= '0;
            for (int e = 0; e < NELEM; e++) tile_q[e] <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        tile_idx <= '0;
                    end else if (tile_valid) begin
                        elem <= '0;
                        for (int e = 0; e < NELEM; e++)
                            tile_q[e] <= tile_data[e*ACC_WIDTH +: ACC_WIDTH];
                    end
                end
                ST_DRAIN: begin
                    if (wr_ready) begin
                        if (elem_last) begin
                            elem <= '0;
                            if (!tile_last) tile_idx <= tile_idx + TIDX_W'(1);
                        end else begin
                            elem <= elem + ELEM_W'(1);
                        end
                    end
                end
                ST_DONE: tile_idx <= '0;
                default: tile_idx <= '0;
            endcase
        end
    end

    tile_addr_gen #(
        .TILE   (TILE),
        .N_SIZE (N_SIZE),
        .ADDR_W (ADDR_W),
        .TIDX_W (TIDX_W),
        .ELEM_W (ELEM_W)
    ) u_addr_gen (
        .tile_idx (tile_idx),
        .elem     (elem),
        .wr_addr  (wr_addr)
    );

    assign elem_val = tile_q[elem];

`ifdef TILE_RESULT_SATURATE_EN
    assign wr_data = (|elem_val[ACC_WIDTH-1:DATA_WIDTH]) ?
                     {DATA_WIDTH{1'b1}} : elem_val[DATA_WIDTH-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^elem_val[ACC_WIDTH-1:DATA_WIDTH];
    assign wr_data   = elem_val[DATA_WIDTH-1:0];
`endif

endmodule
